// File: rtl/key_step_conditioner_if.sv
// Push-button bundle between the board key pins and the key_step_conditioner.
// master: board/stimulus side; slave: conditioner side.
interface key_step_conditioner_if #(
  parameter int unsigned NUM_KEYS = 4
);

  logic [NUM_KEYS-1:0] KEY_n;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                step_pulse;

  modport master (
    output KEY_n,
    input  key_level,
    input  key_press,
    input  key_release,
    input  step_pulse
  );

  modport slave (
    input  KEY_n,
    output key_level,
    output key_press,
    output key_release,
    output step_pulse
  );

endinterface

// File: rtl/key_step_conditioner.sv
// Synchronise and debounce the active-low board keys, emit press/release pulses and a
// single-step enable from key 0; KEY_AUTOREPEAT_EN adds auto-repeat while key 0 is held.
module key_step_conditioner #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input logic                   SYS_clk,
  input logic                   SYS_rst,
  key_step_conditioner_if.slave keys
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Degenerate timing values would break the no-back-to-back step guarantee.
  if (NUM_KEYS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_params
    $error("key_step_conditioner: NUM_KEYS, DEBOUNCE_CYCLES and REPEAT_* must be >= 1");
  end

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] level_q;
  logic [NUM_KEYS-1:0] level_d;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] press_d;
  logic [NUM_KEYS-1:0] release_q;
  logic [NUM_KEYS-1:0] release_d;
  logic [DB_W-1:0]     db_cnt_q [NUM_KEYS];
  logic [DB_W-1:0]     db_cnt_d [NUM_KEYS];
  logic                step_q;
  logic                step_d;

  // Two-flop synchroniser, inverted to active-high.
  always_ff @(posedge SYS_clk) begin
    if (SYS_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~keys.KEY_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a change only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_rst) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  // Limits below 2 would allow a repeat step right after the previous one.
  localparam int unsigned DELAY_EFF  = (REPEAT_DELAY < 2) ? 2 : REPEAT_DELAY;
  localparam int unsigned PERIOD_EFF = (REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD;
  localparam int unsigned RPT_MAX    = (DELAY_EFF > PERIOD_EFF) ? DELAY_EFF : PERIOD_EFF;
  localparam int unsigned RPT_W      = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(DELAY_EFF - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(PERIOD_EFF - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [RPT_W-1:0] rpt_cnt_q;
  logic [RPT_W-1:0] rpt_cnt_d;
  logic             first_q;
  logic             first_d;

  always_ff @(posedge SYS_clk) begin
    if (SYS_rst) begin
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
      first_q   <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      first_q   <= first_d;
      step_q    <= step_d;
    end
  end

  // Step generator: press steps at once, then repeats while held; release wins over a repeat.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    first_d   = first_q;
    step_d    = 1'b0;
    case (state_q)
      IDLE: begin
        step_d = press_d[0];
        if (press_d[0]) begin
          state_d   = HELD;
          rpt_cnt_d = '0;
          first_d   = 1'b1;
        end
      end
      HELD: begin
        if (release_d[0]) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
          first_d   = 1'b0;
        end else if (rpt_cnt_q == (first_q ? DELAY_LAST : PERIOD_LAST)) begin
          step_d    = 1'b1;
          rpt_cnt_d = '0;
          first_d   = 1'b0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
        first_d   = 1'b0;
      end
    endcase
  end
`else
  // One step per debounced press of key 0.
  always_comb begin
    step_d = press_d[0];
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_d;
    end
  end
`endif

  assign keys.key_level   = level_q;
  assign keys.key_press   = press_q;
  assign keys.key_release = release_q;
  assign keys.step_pulse  = step_q;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Directed bench for key_step_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8; expectations follow KEY_AUTOREPEAT_EN when it is defined.
module tb_key_step_conditioner;

  localparam int unsigned NK = 4;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  key_step_conditioner_if #(.NUM_KEYS(NK)) kif ();

  key_step_conditioner #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .SYS_clk (clk),
    .SYS_rst (rst),
    .keys    (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   32'(kif.key_level),   32'h0);
    check({tag, "_press"},   32'(kif.key_press),   32'h0);
    check({tag, "_release"}, 32'(kif.key_release), 32'h0);
    check({tag, "_step"},    32'(kif.step_pulse),  32'h0);
  endtask

  initial begin
    logic exp_step;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    kif.KEY_n = '1;

    // Reset state
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(8);
    check_all_zero("idle");

    // Clean press of key 0, held 50 cycles past the press, then released
    kif.KEY_n[0] = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      tick(1);
      exp_step = (k == 6) || (AR && (k == 26 || k == 34 || k == 42 || k == 50));
      check($sformatf("k0_press@%0d", k),   32'(kif.key_press[0]),   32'(k == 6));
      check($sformatf("k0_level@%0d", k),   32'(kif.key_level[0]),   32'(k >= 6 && k < 56));
      check($sformatf("k0_release@%0d", k), 32'(kif.key_release[0]), 32'(k == 56));
      check($sformatf("k0_step@%0d", k),    32'(kif.step_pulse),     32'(exp_step));
      if (k == 50) kif.KEY_n[0] = 1'b1;
    end

    // Release lands on the second repeat edge and must suppress that step
    kif.KEY_n[0] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      exp_step = (k == 6) || (AR && k == 26);
      check($sformatf("sup_step@%0d", k),    32'(kif.step_pulse),     32'(exp_step));
      check($sformatf("sup_release@%0d", k), 32'(kif.key_release[0]), 32'(k == 34));
      if (k == 28) kif.KEY_n[0] = 1'b1;
    end

    // Bounce on key 1: toggles every 2 cycles, then settles low
    for (int seg = 0; seg < 6; seg++) begin
      kif.KEY_n[1] = (seg % 2 == 1);
      for (int c = 0; c < 2; c++) begin
        tick(1);
        check($sformatf("bnc_press@%0d", seg),   32'(kif.key_press[1]),   32'h0);
        check($sformatf("bnc_release@%0d", seg), 32'(kif.key_release[1]), 32'h0);
        check($sformatf("bnc_level@%0d", seg),   32'(kif.key_level[1]),   32'h0);
      end
    end
    kif.KEY_n[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check($sformatf("bnc_settle_press@%0d", k),   32'(kif.key_press[1]),   32'(k == 6));
      check($sformatf("bnc_settle_release@%0d", k), 32'(kif.key_release[1]), 32'h0);
    end
    kif.KEY_n[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("k1_release@%0d", k), 32'(kif.key_release[1]), 32'(k == 6));
      check($sformatf("k1_press@%0d", k),   32'(kif.key_press[1]),   32'h0);
    end

    // Glitch on key 3 one cycle shorter than the debounce window
    kif.KEY_n[3] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 3) kif.KEY_n[3] = 1'b1;
      check($sformatf("glitch_level@%0d", k),   32'(kif.key_level[3]),   32'h0);
      check($sformatf("glitch_press@%0d", k),   32'(kif.key_press[3]),   32'h0);
      check($sformatf("glitch_release@%0d", k), 32'(kif.key_release[3]), 32'h0);
    end

    // Keys 0, 1 and 2 pressed on the same edge
    kif.KEY_n = 4'b1000;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("sim_press@%0d", k), 32'(kif.key_press), (k == 6) ? 32'h7 : 32'h0);
      check($sformatf("sim_step@%0d", k),  32'(kif.step_pulse), 32'(k == 6));
    end
    check("sim_level", 32'(kif.key_level), 32'h7);

    // Reset while keys are held: everything quiet, then a fresh press afterwards
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      check_all_zero($sformatf("midrst%0d", k));
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("post_press@%0d", k),   32'(kif.key_press), (k == 6) ? 32'h7 : 32'h0);
      check($sformatf("post_step@%0d", k),    32'(kif.step_pulse), 32'(k == 6));
      check($sformatf("post_release@%0d", k), 32'(kif.key_release), 32'h0);
    end
    check("post_level", 32'(kif.key_level), 32'h7);

    kif.KEY_n = '1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("final_release@%0d", k), 32'(kif.key_release), (k == 6) ? 32'h7 : 32'h0);
    end
    check("final_level", 32'(kif.key_level), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
